// File: rtl/ex_pkg.sv
// Shared execute-stage encodings: ALU opcodes, result classes and divider states.
// Decode uses the same opcode and result-class values.
package ex_pkg;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b0;

    localparam logic [7:0] ALU_OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] ALU_OP_AND   = 8'b0010_0100;
    localparam logic [7:0] ALU_OP_OR    = 8'b0010_0101;
    localparam logic [7:0] ALU_OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] ALU_OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] ALU_OP_LUI   = 8'b0101_1100;
    localparam logic [7:0] ALU_OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] ALU_OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] ALU_OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] ALU_OP_MOVZ  = 8'b0000_1010;
    localparam logic [7:0] ALU_OP_MOVN  = 8'b0000_1011;
    localparam logic [7:0] ALU_OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] ALU_OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] ALU_OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] ALU_OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] ALU_OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] ALU_OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] ALU_OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] ALU_OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] ALU_OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] ALU_OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] ALU_OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] ALU_OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] ALU_OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] ALU_OP_DIVU  = 8'b0001_1011;

    localparam logic [2:0] ALU_RES_NOP   = 3'b000;
    localparam logic [2:0] ALU_RES_LOGIC = 3'b001;
    localparam logic [2:0] ALU_RES_SHIFT = 3'b010;
    localparam logic [2:0] ALU_RES_MOVE  = 3'b011;
    localparam logic [2:0] ALU_RES_ARITH = 3'b100;
    localparam logic [2:0] ALU_RES_JUMP  = 3'b110;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU);
    endfunction

    // Ops that only touch HI/LO and must never look like a GPR write to forwarding.
    function automatic logic is_hilo_only_op(input logic [7:0] op);
        return (op == ALU_OP_MULT) || (op == ALU_OP_MULTU) || (op == ALU_OP_DIV) ||
               (op == ALU_OP_DIVU) || (op == ALU_OP_MTHI) || (op == ALU_OP_MTLO);
    endfunction

endpackage

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider with signed fix-up and pipeline stall request.
//   state    | meaning
//   DIV_IDLE | waiting for a DIV/DIVU; stalls the same cycle one arrives
//   DIV_BUSY | one quotient bit per cycle, cnt counts steps taken
//   DIV_DONE | quotient/remainder presented; held while downstream stalls
module div_unit
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic              annul,
    input  logic              stall,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              stallreq,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [2*DATA_W:0] rq;
    logic [DATA_W-1:0] dvsr;
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [2*DATA_W:0] shifted;
    logic [DATA_W:0]   diff;
    logic [2*DATA_W:0] step_rq;

    assign a_mag = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    assign b_mag = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;

    // Upper half holds the partial remainder, lower half shifts in quotient bits.
    always_comb begin
        shifted = {rq[2*DATA_W-1:0], 1'b0};
        diff    = shifted[2*DATA_W:DATA_W] - {1'b0, dvsr};
        step_rq = shifted;
        if (!diff[DATA_W]) begin
            step_rq = {diff, shifted[DATA_W-1:1], 1'b1};
        end
    end

    assign stallreq = ((state == DIV_IDLE) && start) || (state == DIV_BUSY);
    assign done     = (state == DIV_DONE);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= DIV_IDLE;
            cnt       <= '0;
            rq        <= '0;
            dvsr      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (annul) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (divisor == '0) begin
                            quotient  <= '0;
                            remainder <= '0;
                            state     <= DIV_DONE;
                        end else begin
                            rq    <= {{(DATA_W+1){1'b0}}, a_mag};
                            dvsr  <= b_mag;
                            neg_q <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                            neg_r <= signed_op && dividend[DATA_W-1];
                            state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rq  <= step_rq;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        quotient  <= neg_q ? -step_rq[DATA_W-1:0] : step_rq[DATA_W-1:0];
                        remainder <= neg_r ? -step_rq[2*DATA_W-1:DATA_W]
                                           : step_rq[2*DATA_W-1:DATA_W];
                        state     <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!stall) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex.sv
// MIPS execute stage: single-cycle ALU, shifter, moves and multiplier,
// plus the multi-cycle divider that stalls the front of the pipeline.
module ex
    import ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] return_addr_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              stall_i,
    input  logic              annul_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    logic [DATA_W-1:0]   logic_res;
    logic [DATA_W-1:0]   shift_res;
    logic [DATA_W-1:0]   arith_res;
    logic [DATA_W-1:0]   move_res;
    logic                move_ok;
    logic [2*DATA_W-1:0] prod;

    logic                div_start;
    logic                div_stall;
    logic                div_done;
    logic [DATA_W-1:0]   div_quo;
    logic [DATA_W-1:0]   div_rem;

    always_comb begin
        case (aluop_i)
            ALU_OP_AND: logic_res = reg1_i & reg2_i;
            ALU_OP_OR:  logic_res = reg1_i | reg2_i;
            ALU_OP_XOR: logic_res = reg1_i ^ reg2_i;
            ALU_OP_NOR: logic_res = ~(reg1_i | reg2_i);
            ALU_OP_LUI: logic_res = {reg2_i[15:0], 16'h0000};
            default:    logic_res = ZERO_WORD;
        endcase
    end

    always_comb begin
        case (aluop_i)
            ALU_OP_SLL: shift_res = reg2_i << reg1_i[4:0];
            ALU_OP_SRL: shift_res = reg2_i >> reg1_i[4:0];
            ALU_OP_SRA: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
            default:    shift_res = ZERO_WORD;
        endcase
    end

    always_comb begin
        case (aluop_i)
            ALU_OP_ADD, ALU_OP_ADDU: arith_res = reg1_i + reg2_i;
            ALU_OP_SUB, ALU_OP_SUBU: arith_res = reg1_i - reg2_i;
            ALU_OP_SLT:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            ALU_OP_SLTU: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
            default:     arith_res = ZERO_WORD;
        endcase
    end

    always_comb begin
        move_ok = 1'b1;
        case (aluop_i)
            ALU_OP_MFHI: move_res = hi_i;
            ALU_OP_MFLO: move_res = lo_i;
            ALU_OP_MOVZ: begin
                move_res = reg1_i;
                move_ok  = (reg2_i == ZERO_WORD);
            end
            ALU_OP_MOVN: begin
                move_res = reg1_i;
                move_ok  = (reg2_i != ZERO_WORD);
            end
            default:     move_res = ZERO_WORD;
        endcase
    end

    // Sign-extend to full width first so the truncated 64-bit product is exact.
    assign prod = (aluop_i == ALU_OP_MULT)
                ? $signed({{DATA_W{reg1_i[DATA_W-1]}}, reg1_i}) *
                  $signed({{DATA_W{reg2_i[DATA_W-1]}}, reg2_i})
                : {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

    assign div_start = is_div_op(aluop_i) && !annul_i;

    div_unit #(
        .DATA_W     (DATA_W),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .signed_op (aluop_i == ALU_OP_DIV),
        .annul     (annul_i),
        .stall     (stall_i),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .stallreq  (div_stall),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        wd_o       = 5'd0;
        wreg_o     = 1'b0;
        wdata_o    = ZERO_WORD;
        whilo_o    = 1'b0;
        hi_o       = ZERO_WORD;
        lo_o       = ZERO_WORD;
        stallreq_o = 1'b0;
        if (rst != RST_ENABLE) begin
            stallreq_o = div_stall;
            wd_o       = wd_i;
            wreg_o     = wreg_i && move_ok;
            case (alusel_i)
                ALU_RES_LOGIC: wdata_o = logic_res;
                ALU_RES_SHIFT: wdata_o = shift_res;
                ALU_RES_ARITH: wdata_o = arith_res;
                ALU_RES_MOVE:  wdata_o = move_res;
                ALU_RES_JUMP:  wdata_o = return_addr_i;
                default:       wdata_o = ZERO_WORD;
            endcase
            if (is_hilo_only_op(aluop_i)) begin
                wd_o   = 5'd0;
                wreg_o = 1'b0;
            end
            if (div_done) begin
                whilo_o = !annul_i;
                hi_o    = div_rem;
                lo_o    = div_quo;
            end else if ((aluop_i == ALU_OP_MULT) || (aluop_i == ALU_OP_MULTU)) begin
                whilo_o = 1'b1;
                hi_o    = prod[2*DATA_W-1:DATA_W];
                lo_o    = prod[DATA_W-1:0];
            end else if (aluop_i == ALU_OP_MTHI) begin
                whilo_o = 1'b1;
                hi_o    = reg1_i;
                lo_o    = lo_i;
            end else if (aluop_i == ALU_OP_MTLO) begin
                whilo_o = 1'b1;
                hi_o    = hi_i;
                lo_o    = reg1_i;
            end
        end
    end

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: ALU, multiply, divide handshake, annul and reset.
module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] return_addr_i, hi_i, lo_i;
    logic        stall_i, annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int total = 0;
    int fails = 0;
    int n;
    int hits;

    ex dut (
        .clk           (clk),
        .rst           (rst),
        .aluop_i       (aluop_i),
        .alusel_i      (alusel_i),
        .reg1_i        (reg1_i),
        .reg2_i        (reg2_i),
        .wd_i          (wd_i),
        .wreg_i        (wreg_i),
        .return_addr_i (return_addr_i),
        .hi_i          (hi_i),
        .lo_i          (lo_i),
        .stall_i       (stall_i),
        .annul_i       (annul_i),
        .wd_o          (wd_o),
        .wreg_o        (wreg_o),
        .wdata_o       (wdata_o),
        .whilo_o       (whilo_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .stallreq_o    (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b, input logic we);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wreg_i   = we;
        wd_i     = we ? 5'd9 : 5'd0;
        #1;
    endtask

    // Applies a divide and counts stalled cycles until the stall drops (bounded).
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int cnt);
        set_op(op, ALU_RES_NOP, a, b, 1'b0);
        cnt = 0;
        while (stallreq_o === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        aluop_i = ALU_OP_NOP; alusel_i = ALU_RES_NOP;
        reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
        return_addr_i = 32'h0040_0010; hi_i = 32'h0000_1234; lo_i = 32'h0000_5555;
        stall_i = 1'b0; annul_i = 1'b0;
        tick();
        tick();

        set_op(ALU_OP_ADDU, ALU_RES_ARITH, 32'd5, 32'd3, 1'b1);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_wreg", wreg_o, 1'b0);
        chk("rst_wd", wd_o, 5'd0);
        chk("rst_stallreq", stallreq_o, 1'b0);

        tick();
        rst = 1'b1;
        set_op(ALU_OP_ADDU, ALU_RES_ARITH, 32'h7FFF_FFFF, 32'h1, 1'b1);
        chk("addu_wdata", wdata_o, 32'h8000_0000);
        chk("addu_wreg", wreg_o, 1'b1);
        chk("addu_wd", wd_o, 5'd9);
        set_op(ALU_OP_SLT, ALU_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 1'b1);
        chk("slt", wdata_o, 32'h1);
        set_op(ALU_OP_SLTU, ALU_RES_ARITH, 32'hFFFF_FFFF, 32'h1, 1'b1);
        chk("sltu", wdata_o, 32'h0);
        set_op(ALU_OP_SUBU, ALU_RES_ARITH, 32'd5, 32'd7, 1'b1);
        chk("subu", wdata_o, 32'hFFFF_FFFE);
        set_op(ALU_OP_XOR, ALU_RES_LOGIC, 32'h0000_F0F0, 32'h0000_FF00, 1'b1);
        chk("xor", wdata_o, 32'h0000_0FF0);
        set_op(ALU_OP_NOR, ALU_RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 1'b1);
        chk("nor", wdata_o, 32'hF0F0_FF00);
        set_op(ALU_OP_SRA, ALU_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1);
        chk("sra", wdata_o, 32'hF800_0000);
        set_op(ALU_OP_SRL, ALU_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1);
        chk("srl", wdata_o, 32'h0800_0000);
        set_op(ALU_OP_MOVZ, ALU_RES_MOVE, 32'hABCD, 32'h1, 1'b1);
        chk("movz_fail_wreg", wreg_o, 1'b0);
        set_op(ALU_OP_MOVN, ALU_RES_MOVE, 32'hABCD, 32'h1, 1'b1);
        chk("movn_wreg", wreg_o, 1'b1);
        chk("movn_wdata", wdata_o, 32'hABCD);
        set_op(ALU_OP_MFHI, ALU_RES_MOVE, 32'h0, 32'h0, 1'b1);
        chk("mfhi", wdata_o, 32'h0000_1234);
        set_op(ALU_OP_NOP, ALU_RES_JUMP, 32'h0, 32'h0, 1'b1);
        chk("jump", wdata_o, 32'h0040_0010);

        set_op(ALU_OP_MULT, ALU_RES_NOP, 32'hFFFF_FFFF, 32'h2, 1'b0);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFFE);
        chk("mult_whilo", whilo_o, 1'b1);
        chk("mult_stall", stallreq_o, 1'b0);
        chk("mult_wreg", wreg_o, 1'b0);
        set_op(ALU_OP_MULTU, ALU_RES_NOP, 32'hFFFF_FFFF, 32'h2, 1'b0);
        chk("multu_hi", hi_o, 32'h1);
        chk("multu_lo", lo_o, 32'hFFFF_FFFE);
        set_op(ALU_OP_MTHI, ALU_RES_NOP, 32'hAAAA, 32'h0, 1'b0);
        chk("mthi_hi", hi_o, 32'hAAAA);
        chk("mthi_lo", lo_o, 32'h5555);
        chk("mthi_whilo", whilo_o, 1'b1);

        run_div(ALU_OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_stall_cycles", n, 33);
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);
        chk("div_whilo", whilo_o, 1'b1);
        chk("div_wreg", wreg_o, 1'b0);
        set_op(ALU_OP_NOP, ALU_RES_NOP, 32'h0, 32'h0, 1'b0);
        tick();
        chk("div_after_whilo", whilo_o, 1'b0);
        chk("div_after_stall", stallreq_o, 1'b0);

        run_div(ALU_OP_DIVU, 32'd100, 32'd7, n);
        chk("divu_stall_cycles", n, 33);
        chk("divu_lo", lo_o, 32'd14);
        chk("divu_hi", hi_o, 32'd2);
        // Downstream stall in DONE: results must hold for three cycles.
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("divu_hold_lo", lo_o, 32'd14);
            chk("divu_hold_hi", hi_o, 32'd2);
            chk("divu_hold_whilo", whilo_o, 1'b1);
            if (i < 2) tick();
        end
        stall_i = 1'b0;
        set_op(ALU_OP_NOP, ALU_RES_NOP, 32'h0, 32'h0, 1'b0);
        tick();
        chk("divu_release_whilo", whilo_o, 1'b0);

        run_div(ALU_OP_DIVU, 32'd55, 32'd0, n);
        chk("div0_stall_cycles", n, 1);
        chk("div0_hi", hi_o, 32'h0);
        chk("div0_lo", lo_o, 32'h0);
        chk("div0_whilo", whilo_o, 1'b1);
        set_op(ALU_OP_NOP, ALU_RES_NOP, 32'h0, 32'h0, 1'b0);
        tick();

        set_op(ALU_OP_DIV, ALU_RES_NOP, 32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("annul_busy_stall", stallreq_o, 1'b1);
        annul_i = 1'b1;
        set_op(ALU_OP_NOP, ALU_RES_NOP, 32'h0, 32'h0, 1'b0);
        tick();
        annul_i = 1'b0;
        #1;
        chk("annul_stall", stallreq_o, 1'b0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (whilo_o === 1'b1) hits++;
            tick();
        end
        chk("annul_no_whilo", hits, 0);
        run_div(ALU_OP_DIVU, 32'd100, 32'd7, n);
        chk("annul_restart_cycles", n, 33);
        chk("annul_restart_lo", lo_o, 32'd14);
        set_op(ALU_OP_NOP, ALU_RES_NOP, 32'h0, 32'h0, 1'b0);
        tick();

        set_op(ALU_OP_DIV, ALU_RES_NOP, 32'd1000, 32'd3, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        tick();
        chk("rstmid_stall", stallreq_o, 1'b0);
        chk("rstmid_whilo", whilo_o, 1'b0);
        chk("rstmid_hi", hi_o, 32'h0);
        chk("rstmid_lo", lo_o, 32'h0);
        set_op(ALU_OP_SLL, ALU_RES_SHIFT, 32'd31, 32'd1, 1'b1);
        chk("rstmid_wdata", wdata_o, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("sll_wdata", wdata_o, 32'h8000_0000);
        chk("sll_stall", stallreq_o, 1'b0);
        tick();
        chk("sll_idle_stall", stallreq_o, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
